mc_ctrl: RTL and testbench

Parametrised multicycle controller for the single-issue MIPS-subset datapath: a five-state FSM (FETCH/DCD/EXE/MEM/WB) driving PC, IR, register-file, data-memory and mux selects. It supersedes the Fetch/Exe-only controller with a full instruction subset, per-instruction state sequencing and a memory wait-state handshake. It adds an illegal-opcode flag and a retired-instruction counter. It sits between the IR fields (`Op`, `Funct`) plus ALU `Zero`, and every datapath enable/select.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_ctrl_instr_decode.sv | 68 ++++++
 rtl/mc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS-subset controller:
//               FSM state codes, datapath select encodings and the opcode /
//               funct values that the controller and datapath both decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM states; numeric values are visible on the state output.
    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    // Next-PC source
    localparam logic [1:0] C_NPC_PLUS4  = 2'b00;
    localparam logic [1:0] C_NPC_BRANCH = 2'b01;
    localparam logic [1:0] C_NPC_JUMP   = 2'b10;
    localparam logic [1:0] C_NPC_JR     = 2'b11;

    // ALU operation (3-bit core code, zero-extended to ALUOP_W at the top)
    localparam logic [2:0] C_ALU_ADDU = 3'd0;
    localparam logic [2:0] C_ALU_SUBU = 3'd1;
    localparam logic [2:0] C_ALU_AND  = 3'd2;
    localparam logic [2:0] C_ALU_OR   = 3'd3;
    localparam logic [2:0] C_ALU_SLT  = 3'd4;

    // ALU B operand source
    localparam logic C_BSEL_RD2 = 1'b0;
    localparam logic C_BSEL_IMM = 1'b1;

    // Register-file write address source
    localparam logic [1:0] C_GPR_RD = 2'd0;
    localparam logic [1:0] C_GPR_RT = 2'd1;
    localparam logic [1:0] C_GPR_RA = 2'd2;

    // Register-file write data source
    localparam logic [1:0] C_WD_ALU = 2'd0;
    localparam logic [1:0] C_WD_MEM = 2'd1;
    localparam logic [1:0] C_WD_PC  = 2'd2;

    // Opcodes (IR[31:26])
    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDIU = 6'h09;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    // Funct codes (IR[5:0]) for Op = 0
    localparam logic [5:0] C_FN_JR   = 6'h08;
    localparam logic [5:0] C_FN_ADDU = 6'h21;
    localparam logic [5:0] C_FN_SUBU = 6'h23;
    localparam logic [5:0] C_FN_AND  = 6'h24;
    localparam logic [5:0] C_FN_OR   = 6'h25;
    localparam logic [5:0] C_FN_SLT  = 6'h2A;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_instr_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode
// Description : Combinational instruction classifier. Maps Op/Funct onto a
//               one-hot set of class flags and supplies the ALU operation
//               for ALU-type R instructions.
// Ports       : op, funct        - IR opcode and funct fields
//               rtype            - addu/subu/and/or/slt
//               itype_alu        - ori/addiu
//               ld, st, br       - lw, sw, beq/bne
//               j, jal, jr       - jumps
//               illegal          - anything not listed above
//               alu_op           - ALU code for rtype (0 otherwise)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       rtype,
    output logic       itype_alu,
    output logic       ld,
    output logic       st,
    output logic       br,
    output logic       j,
    output logic       jal,
    output logic       jr,
    output logic       illegal,
    output logic [2:0] alu_op
);

    always_comb begin
        rtype     = 1'b0;
        itype_alu = 1'b0;
        ld        = 1'b0;
        st        = 1'b0;
        br        = 1'b0;
        j         = 1'b0;
        jal       = 1'b0;
        jr        = 1'b0;
        illegal   = 1'b0;
        alu_op    = C_ALU_ADDU;

        case (op)
            C_OP_RTYPE: begin
                case (funct)
                    C_FN_ADDU: begin rtype = 1'b1; alu_op = C_ALU_ADDU; end
                    C_FN_SUBU: begin rtype = 1'b1; alu_op = C_ALU_SUBU; end
                    C_FN_AND:  begin rtype = 1'b1; alu_op = C_ALU_AND;  end
                    C_FN_OR:   begin rtype = 1'b1; alu_op = C_ALU_OR;   end
                    C_FN_SLT:  begin rtype = 1'b1; alu_op = C_ALU_SLT;  end
                    C_FN_JR:   jr      = 1'b1;
                    default:   illegal = 1'b1;
                endcase
            end
            C_OP_ORI, C_OP_ADDIU: itype_alu = 1'b1;
            C_OP_LW:              ld        = 1'b1;
            C_OP_SW:              st        = 1'b1;
            C_OP_BEQ, C_OP_BNE:   br        = 1'b1;
            C_OP_J:               j         = 1'b1;
            C_OP_JAL:             jal       = 1'b1;
            default:              illegal   = 1'b1;
        endcase
    end

endmodule : instr_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle controller for the MIPS-subset datapath. Five-state
//               FSM (FETCH/DCD/EXE/MEM/WB) with per-instruction sequencing,
//               memory wait-state handshake, illegal-opcode pulse and a
//               retired-instruction counter.
// Ports       : clk, rst (async, active high)
//               Op, Funct, Zero, mem_ready          - inputs from IR/ALU/memory
//               state                               - current FSM state
//               mem_req, PCWr, IRWr, RFWr, DMWr     - request / write enables
//               NPCOp, ALUOp, EXTOp, BSel, GPRSel, WDSel - datapath selects
//               illegal, retire                     - one-cycle event pulses
//               instr_cnt                           - retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32,
    parameter bit MEM_HS  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               mem_req,
    output logic               PCWr,
    output logic               IRWr,
    output logic               RFWr,
    output logic               DMWr,
    output logic [1:0]         NPCOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               EXTOp,
    output logic               BSel,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               illegal,
    output logic               retire,
    output logic [CNT_W-1:0]   instr_cnt
);

    generate
        if (ALUOP_W < 3) begin : g_aluop_w_check
            $error("mc_ctrl: ALUOP_W must be at least 3");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [2:0]       w_alu_op;
    logic             w_ready;

    logic w_rtype, w_itype_alu, w_ld, w_st, w_br, w_j, w_jal, w_jr, w_illegal;
    logic [2:0] w_rtype_alu;

    // Without the handshake, every memory access completes in one cycle.
    assign w_ready = MEM_HS ? mem_ready : 1'b1;

    instr_decode u_instr_decode (
        .op        (Op),
        .funct     (Funct),
        .rtype     (w_rtype),
        .itype_alu (w_itype_alu),
        .ld        (w_ld),
        .st        (w_st),
        .br        (w_br),
        .j         (w_j),
        .jal       (w_jal),
        .jr        (w_jr),
        .illegal   (w_illegal),
        .alu_op    (w_rtype_alu)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        PCWr         = 1'b0;
        IRWr         = 1'b0;
        RFWr         = 1'b0;
        DMWr         = 1'b0;
        NPCOp        = C_NPC_PLUS4;
        w_alu_op     = C_ALU_ADDU;
        EXTOp        = 1'b0;
        BSel         = C_BSEL_RD2;
        GPRSel       = C_GPR_RD;
        WDSel        = C_WD_ALU;
        illegal      = 1'b0;
        retire       = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (w_ready) begin
                    IRWr         = 1'b1;
                    PCWr         = 1'b1;
                    NPCOp        = C_NPC_PLUS4;
                    w_next_state = S_DCD;
                end
            end

            S_DCD: begin
                if (w_j || w_jal) begin
                    PCWr         = 1'b1;
                    NPCOp        = C_NPC_JUMP;
                    retire       = 1'b1;
                    w_next_state = S_FETCH;
                    if (w_jal) begin
                        RFWr   = 1'b1;
                        GPRSel = C_GPR_RA;
                        WDSel  = C_WD_PC;
                    end
                end else if (w_jr) begin
                    PCWr         = 1'b1;
                    NPCOp        = C_NPC_JR;
                    retire       = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_illegal) begin
                    illegal      = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_EXE;
                end
            end

            S_EXE: begin
                w_next_state = S_FETCH;
                if (w_rtype) begin
                    BSel         = C_BSEL_RD2;
                    w_alu_op     = w_rtype_alu;
                    w_next_state = S_WB;
                end else if (w_itype_alu) begin
                    BSel         = C_BSEL_IMM;
                    // ori zero-extends its immediate, addiu sign-extends.
                    EXTOp        = (Op != C_OP_ORI);
                    w_alu_op     = (Op == C_OP_ORI) ? C_ALU_OR : C_ALU_ADDU;
                    w_next_state = S_WB;
                end else if (w_ld || w_st) begin
                    BSel         = C_BSEL_IMM;
                    EXTOp        = 1'b1;
                    w_alu_op     = C_ALU_ADDU;
                    w_next_state = S_MEM;
                end else if (w_br) begin
                    BSel     = C_BSEL_RD2;
                    EXTOp    = 1'b1;
                    w_alu_op = C_ALU_SUBU;
                    NPCOp    = C_NPC_BRANCH;
                    // Zero comes from rs - rt; bne takes the branch on non-zero.
                    PCWr     = (Op == C_OP_BNE) ? ~Zero : Zero;
                    retire   = 1'b1;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                if (w_ready) begin
                    if (w_st) begin
                        DMWr         = 1'b1;
                        retire       = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end

            S_WB: begin
                RFWr         = 1'b1;
                retire       = 1'b1;
                w_next_state = S_FETCH;
                if (w_ld) begin
                    GPRSel = C_GPR_RT;
                    WDSel  = C_WD_MEM;
                end else if (w_itype_alu) begin
                    GPRSel = C_GPR_RT;
                    WDSel  = C_WD_ALU;
                end else begin
                    GPRSel = C_GPR_RD;
                    WDSel  = C_WD_ALU;
                end
            end

            default: w_next_state = S_FETCH;
        endcase

        // Reset holds every enable and event low even though the state
        // register already reads FETCH.
        if (rst) begin
            mem_req = 1'b0;
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RFWr    = 1'b0;
            DMWr    = 1'b0;
            illegal = 1'b0;
            retire  = 1'b0;
        end
    end

    assign ALUOp = ALUOP_W'(w_alu_op);
    assign state = r_state;

    // ------------------------------------------------------------------
    // Retired-instruction counter (wraps naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_cnt <= '0;
        end else if (retire) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    assign instr_cnt = r_instr_cnt;

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. Each instruction is expanded
//               into a per-cycle script of expected outputs built from the
//               instruction set rules; a compare process checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, pcwr, irwr, rfwr, dmwr;
        logic [1:0] npc;
        logic [2:0] alu;
        logic       ext, bsel;
        logic [1:0] gpr, wd;
        logic       ill, ret;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
    } entry_t;

    // instruction kinds for the model
    localparam int K_R = 0, K_ORI = 1, K_ADDIU = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                   K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = '0, Funct = '0;
    logic       Zero = 1'b0, mem_ready = 1'b0;
    logic [2:0] state;
    logic       mem_req, PCWr, IRWr, RFWr, DMWr, EXTOp, BSel, illegal, retire;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic [2:0] ALUOp;
    logic [CNT_W-1:0] instr_cnt;

    int     tests = 0;
    int     fails = 0;
    int     m_cnt = 0;
    entry_t script[$];
    entry_t cur;
    logic   cur_valid = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl #(.ALUOP_W(3), .CNT_W(CNT_W), .MEM_HS(1'b1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .state(state), .mem_req(mem_req),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .NPCOp(NPCOp),
        .ALUOp(ALUOp), .EXTOp(EXTOp), .BSel(BSel), .GPRSel(GPRSel),
        .WDSel(WDSel), .illegal(illegal), .retire(retire), .instr_cnt(instr_cnt)
    );

    // ---------------- model ----------------
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h08) return K_JR;
            if (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                return K_R;
            return K_ILL;
        end
        case (op)
            6'h0D: return K_ORI;
            6'h09: return K_ADDIU;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] rfn_alu(input logic [5:0] fn);
        case (fn)
            6'h23:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h2A:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic vec_t blank(input int st);
        vec_t v = '0;
        v.st = 3'(st);
        return v;
    endfunction

    // mr / z of -1 mean "don't care": drive a random level.
    task automatic push(input vec_t v, input int mr, input int z,
                        input logic [5:0] op, input logic [5:0] fn);
        entry_t e;
        e.v     = v;
        e.v.cnt = 4'(m_cnt);
        e.mr    = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
        e.z     = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
        e.op    = op;
        e.fn    = fn;
        script.push_back(e);
        if (v.ret) m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int z, input int fw, input int mw);
        int   k = kind_of(op, fn);
        int   zz = (k == K_BEQ || k == K_BNE) ? z : -1;
        vec_t v;
        for (int i = 0; i < fw; i++) begin
            v = blank(0); v.mreq = 1'b1; push(v, 0, zz, op, fn);
        end
        v = blank(0); v.mreq = 1'b1; v.irwr = 1'b1; v.pcwr = 1'b1;
        push(v, 1, zz, op, fn);
        v = blank(1);
        if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) begin
            if (k == K_ILL) v.ill = 1'b1;
            else begin
                v.pcwr = 1'b1; v.ret = 1'b1;
                v.npc  = (k == K_JR) ? 2'd3 : 2'd2;
                if (k == K_JAL) begin v.rfwr = 1'b1; v.gpr = 2'd2; v.wd = 2'd2; end
            end
            push(v, -1, zz, op, fn);
            return;
        end
        push(v, -1, zz, op, fn);
        v = blank(2);
        case (k)
            K_R:     v.alu = rfn_alu(fn);
            K_ORI:   begin v.bsel = 1'b1; v.alu = 3'd3; end
            K_ADDIU, K_LW, K_SW: begin v.bsel = 1'b1; v.ext = 1'b1; end
            default: begin
                v.alu = 3'd1; v.ext = 1'b1; v.npc = 2'd1; v.ret = 1'b1;
                v.pcwr = (k == K_BEQ) ? (z == 1) : (z == 0);
            end
        endcase
        push(v, -1, zz, op, fn);
        if (k == K_BEQ || k == K_BNE) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < mw; i++) begin
                v = blank(3); v.mreq = 1'b1; push(v, 0, zz, op, fn);
            end
            v = blank(3); v.mreq = 1'b1;
            if (k == K_SW) begin v.dmwr = 1'b1; v.ret = 1'b1; end
            push(v, 1, zz, op, fn);
            if (k == K_SW) return;
        end
        v = blank(4); v.rfwr = 1'b1; v.ret = 1'b1;
        if (k == K_LW)       begin v.gpr = 2'd1; v.wd = 2'd1; end
        else if (k != K_R)   v.gpr = 2'd1;
        push(v, -1, zz, op, fn);
    endtask

    // Apply up to 'limit' script entries; if the script completes, take one
    // extra edge so the DUT is parked in FETCH with mem_ready low.
    task automatic run_script(input int limit, output int ncyc);
        ncyc = 0;
        while (script.size() > 0 && ncyc < limit) begin
            @(posedge clk); #1;
            cur       = script.pop_front();
            Op        = cur.op;
            Funct     = cur.fn;
            Zero      = cur.z;
            mem_ready = cur.mr;
            cur_valid = 1'b1;
            ncyc++;
        end
        if (script.size() == 0) begin
            @(posedge clk); #1;
            cur_valid = 1'b0;
            mem_ready = 1'b0;
        end
    endtask

    task automatic check_lit(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cur_valid) begin
            vec_t got;
            got = {state, mem_req, PCWr, IRWr, RFWr, DMWr, NPCOp, ALUOp, EXTOp,
                   BSel, GPRSel, WDSel, illegal, retire, instr_cnt};
            tests++;
            if (got !== cur.v) begin
                fails++;
                $display("FAIL cycle op=%h fn=%h: got %b expected %b",
                         cur.op, cur.fn, got, cur.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_lit("rst_state", state, 0);
        check_lit("rst_mem_req", mem_req, 0);
        check_lit("rst_cnt", instr_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check_lit("fetch_mem_req", mem_req, 1);

        add_instr(6'h00, 6'h21, -1, 0, 0); run_script(100, n);   // addu
        check_lit("addu_cycles", n, 4);
        check_lit("addu_cnt", instr_cnt, 1);

        add_instr(6'h23, 6'h00, -1, 0, 3); run_script(100, n);   // lw, 3 waits
        check_lit("lw_cycles", n, 8);
        check_lit("lw_cnt", instr_cnt, 2);

        add_instr(6'h04, 6'h00, 1, 0, 0); run_script(100, n);    // beq taken
        check_lit("beq_t_cycles", n, 3);
        add_instr(6'h04, 6'h00, 0, 0, 0); run_script(100, n);    // beq not taken
        check_lit("beq_nt_cycles", n, 3);
        check_lit("beq_cnt", instr_cnt, 4);

        add_instr(6'h03, 6'h00, -1, 0, 0); run_script(100, n);   // jal
        check_lit("jal_cycles", n, 2);
        check_lit("jal_state", state, 0);

        add_instr(6'h3F, 6'h00, -1, 0, 0); run_script(100, n);   // illegal op
        check_lit("ill_cycles", n, 2);
        check_lit("ill_cnt", instr_cnt, 5);

        add_instr(6'h00, 6'h23, -1, 0, 0);   // subu   -> 6
        add_instr(6'h00, 6'h24, -1, 1, 0);   // and    -> 7
        add_instr(6'h00, 6'h25, -1, 0, 0);   // or     -> 8
        add_instr(6'h00, 6'h2A, -1, 0, 0);   // slt    -> 9
        add_instr(6'h00, 6'h08, -1, 0, 0);   // jr     -> 10
        add_instr(6'h0D, 6'h00, -1, 0, 0);   // ori    -> 11
        add_instr(6'h09, 6'h00, -1, 0, 0);   // addiu  -> 12
        add_instr(6'h2B, 6'h00, -1, 2, 1);   // sw     -> 13
        add_instr(6'h05, 6'h00, 0, 0, 0);    // bne taken     -> 14
        add_instr(6'h05, 6'h00, 1, 0, 0);    // bne not taken -> 15
        add_instr(6'h02, 6'h00, -1, 0, 0);   // j: 16th retire wraps to 0
        run_script(1000, n);
        check_lit("wrap_cnt", instr_cnt, 0);

        add_instr(6'h23, 6'h00, -1, 1, 0);   // lw
        add_instr(6'h00, 6'h3F, -1, 0, 0);   // illegal funct
        add_instr(6'h00, 6'h21, -1, 2, 0);   // addu with fetch waits
        run_script(1000, n);
        check_lit("post_wrap_cnt", instr_cnt, 2);

        // reset in the middle of an sw MEM wait
        add_instr(6'h2B, 6'h00, -1, 0, 5);
        run_script(5, n);                    // fetch, dcd, exe, 2 MEM waits
        @(negedge clk); #2;
        cur_valid = 1'b0;
        script.delete();
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_lit("mid_rst_state", state, 0);
        check_lit("mid_rst_cnt", instr_cnt, 0);
        check_lit("mid_rst_dmwr", DMWr, 0);
        check_lit("mid_rst_mem_req", mem_req, 0);
        repeat (2) begin
            @(negedge clk);
            check_lit("rst_hold_dmwr", DMWr, 0);
            check_lit("rst_hold_state", state, 0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst = 1'b0;
        m_cnt = 0;
        add_instr(6'h00, 6'h21, -1, 0, 0); run_script(100, n);
        check_lit("after_rst_cnt", instr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mc_ctrl
`default_nettype wire
